intt_butterfly: RTL

INTT_BUTTERFLY -- requirements
Module: intt_butterfly

---
 rtl/intt_butterfly_if.sv | 26 ++
 rtl/intt_butterfly.sv | 89 ++++++++
 2 files changed

// File: rtl/intt_butterfly_if.sv
// Handshake and operand bundle for the inverse-NTT butterfly.
// The slave side is the butterfly; the master side is whoever feeds and drains it.
interface intt_butterfly_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_zeta;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;

  modport master (
    output in_valid, in_a, in_b, in_zeta, in_mode, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );

  modport slave (
    input  in_valid, in_a, in_b, in_zeta, in_mode, out_ready,
    output in_ready, out_valid, out_a, out_b
  );
endinterface

// File: rtl/intt_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: a' = a+b, b' = zeta*(b-a) (or b-a), all mod Q.
// Three-stage pipeline (add/sub, multiply, Barrett reduce) with a global advance enable.
module intt_butterfly #(
  parameter int Q = 3329,
  parameter int W = 12
) (
  input logic              clk,
  input logic              rst_n,
  intt_butterfly_if.slave  bus
);

  localparam int              KB        = 2 * W;
  localparam logic [W:0]      Q_EXT     = (W+1)'(Q);
  localparam logic [2*W-1:0]  Q_WIDE    = (2*W)'(Q);
  // floor(2^(2W) / Q); products are below Q^2 < 2^(2W), so the quotient estimate is short by at most one.
  localparam logic [W+1:0]    BARRETT_M = (W+2)'((64'd1 << KB) / 64'(Q));

  logic adv;

  logic         s1_valid, s2_valid, out_valid_q;
  logic [W-1:0] s1_sum, s1_diff, s1_zeta, s2_sum;
  logic         s1_mode, s2_mode;
  logic [2*W-1:0] s2_prod;
  logic [W-1:0] out_a_q, out_b_q;

  logic [W:0]          sum_raw, sum_red;
  logic signed [W+1:0] diff_raw;
  logic [W+1:0]        diff_red;

  logic [3*W+1:0] bm_prod;
  logic [W+1:0]   q_est;
  logic [2*W-1:0] q_est_wide;
  logic [W:0]     rem;
  logic [W-1:0]   prod_red;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;

  // NOTE: every variable here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    sum_raw  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    sum_red  = (sum_raw >= Q_EXT) ? sum_raw - Q_EXT : sum_raw;
    diff_raw = $signed({2'b00, bus.in_b}) - $signed({2'b00, bus.in_a});
    diff_red = diff_raw[W+1] ? $unsigned(diff_raw) + {1'b0, Q_EXT} : $unsigned(diff_raw);
  end

  always_comb begin
    bm_prod    = {{(W+2){1'b0}}, s2_prod} * {{(2*W){1'b0}}, BARRETT_M};
    q_est      = (W+2)'(bm_prod >> KB);
    q_est_wide = {{(W-2){1'b0}}, q_est};
    rem        = (W+1)'(s2_prod - q_est_wide * Q_WIDE);
    prod_red   = W'((rem >= Q_EXT) ? rem - Q_EXT : rem);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      out_a_q     <= s2_sum;
      out_b_q     <= s2_mode ? W'(s2_prod) : prod_red;
    end
  end

  // NOTE: interior data registers carry no reset; their contents are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sum  <= W'(sum_red);
      s1_diff <= W'(diff_red);
      s1_zeta <= bus.in_zeta;
      s1_mode <= bus.in_mode;
      s2_sum  <= s1_sum;
      s2_mode <= s1_mode;
      s2_prod <= s1_mode ? {{W{1'b0}}, s1_diff}
                         : {{W{1'b0}}, s1_diff} * {{W{1'b0}}, s1_zeta};
    end
  end

endmodule
